// File: rtl/crc_stream.sv
// Parametrised framed CRC engine: bit-serial-per-beat update in one cycle,
// held result with valid/ready handoff and residue-based frame check.
module crc_stream #(
  parameter int unsigned          CRC_WIDTH   = 8,
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL  = 8'h07,
  parameter logic [CRC_WIDTH-1:0] INIT        = '0,
  parameter bit                   REFLECT_IN  = 1'b0,
  parameter bit                   REFLECT_OUT = 1'b0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = '0,
  parameter logic [CRC_WIDTH-1:0] RESIDUE     = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  data_last_i,
  output logic                  data_ready_o,
  output logic [CRC_WIDTH-1:0]  crc_o,
  output logic                  crc_valid_o,
  input  logic                  crc_ready_i,
  output logic                  check_ok_o
);

  if (CRC_WIDTH < 1 || CRC_WIDTH > 64) begin : g_bad_crc_width
    $error("crc_stream: CRC_WIDTH must be in 1..64");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_data_width
    $error("crc_stream: DATA_WIDTH must be in 1..64");
  end

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                state_q, state_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d, crc_step, crc_ord;
  logic [DATA_WIDTH-1:0] data_ord;
  logic                  fb;
  logic                  accept;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  // Next-state logic; clear_i overrides any transition
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: if (data_valid_i && data_last_i) state_d = HOLD;
        HOLD:  if (crc_ready_i)                 state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Output logic
  always_comb begin
    data_ready_o = (state_q == ACCUM) && !clear_i;
    crc_valid_o  = (state_q == HOLD);
    accept       = data_valid_i && data_ready_o;
  end

  // Whole beat folded in MSB-first within a single cycle
  always_comb begin
    fb       = 1'b0;
    data_ord = data_i;
    if (REFLECT_IN) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) data_ord[i] = data_i[DATA_WIDTH-1-i];
    end
    crc_step = crc_q;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      fb       = crc_step[CRC_WIDTH-1] ^ data_ord[DATA_WIDTH-1-i];
      crc_step = (crc_step << 1) ^ (fb ? POLYNOMIAL : '0);
    end
  end

  always_comb begin
    crc_d = crc_q;
    if (clear_i)                               crc_d = INIT;
    else if (accept)                           crc_d = crc_step;
    else if (state_q == HOLD && crc_ready_i)   crc_d = INIT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= INIT;
    else         crc_q <= crc_d;
  end

  always_comb begin
    crc_ord = crc_q;
    if (REFLECT_OUT) begin
      for (int unsigned i = 0; i < CRC_WIDTH; i++) crc_ord[i] = crc_q[CRC_WIDTH-1-i];
    end
    crc_o      = crc_ord ^ XOR_OUT;
    check_ok_o = (crc_q == RESIDUE);
  end

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: CRC-8, CRC-16 (8/16-bit beats) and reflected CRC-32.
module tb_crc_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Shared stimulus for the three 8-bit-beat instances
  logic       rst_n, clear, valid, last, cready;
  logic [7:0] data;

  logic        rdy8, cv8, ok8;
  logic [7:0]  crc8;
  logic        rdy16, cv16, ok16;
  logic [15:0] crc16;
  logic        rdy32, cv32, ok32;
  logic [31:0] crc32;

  // 16-bit-beat instance has its own stimulus
  logic        vw, lw, crw;
  logic [15:0] dw;
  logic        rdyw, cvw, okw;
  logic [15:0] crcw;

  crc_stream u_crc8 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
    .data_valid_i(valid), .data_last_i(last), .data_ready_o(rdy8),
    .crc_o(crc8), .crc_valid_o(cv8), .crc_ready_i(cready), .check_ok_o(ok8)
  );

  crc_stream #(.CRC_WIDTH(16), .POLYNOMIAL(16'h1021), .INIT(16'hFFFF)) u_crc16 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
    .data_valid_i(valid), .data_last_i(last), .data_ready_o(rdy16),
    .crc_o(crc16), .crc_valid_o(cv16), .crc_ready_i(cready), .check_ok_o(ok16)
  );

  crc_stream #(.CRC_WIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF),
               .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF)) u_crc32 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
    .data_valid_i(valid), .data_last_i(last), .data_ready_o(rdy32),
    .crc_o(crc32), .crc_valid_o(cv32), .crc_ready_i(cready), .check_ok_o(ok32)
  );

  crc_stream #(.CRC_WIDTH(16), .DATA_WIDTH(16), .POLYNOMIAL(16'h1021), .INIT(16'hFFFF)) u_crcw (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(dw),
    .data_valid_i(vw), .data_last_i(lw), .data_ready_o(rdyw),
    .crc_o(crcw), .crc_valid_o(cvw), .crc_ready_i(crw), .check_ok_o(okw)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Byte-at-a-time CRC-16/CCITT-FALSE over eight bytes, used for the 16-bit-beat case
  function automatic logic [15:0] ccitt8(input logic [63:0] msg);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int b = 0; b < 8; b++) begin
      c = c ^ {msg[63-8*b -: 8], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic send(input logic [7:0] b, input logic l);
    data = b; valid = 1'b1; last = l;
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
  endtask

  // "123456789"; idle gaps drive data_last_i without data_valid_i
  task automatic send_msg(input logic with_last, input int unsigned max_gap);
    for (int i = 0; i < 9; i++) begin
      send(8'(8'h31 + i), with_last && (i == 8));
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          last = 1'b1; data = 8'hA5;
          @(posedge clk); #1;
          last = 1'b0;
        end
      end
    end
  endtask

  task automatic handoff();
    cready = 1'b1;
    @(posedge clk); #1;
    cready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid = 1'b0; last = 1'b0; cready = 1'b0; data = '0;
    vw = 1'b0; lw = 1'b0; crw = 1'b0; dw = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_crc8",  64'(crc8), 64'h00);
    chk("rst_valid", 64'(cv8), 64'h0);
    chk("rst_ok",    64'(ok8), 64'h1);
    chk("rst_ready", 64'(rdy8), 64'h1);
    chk("rst_crc16", 64'(crc16), 64'hFFFF);
    chk("rst_crc32", 64'(crc32), 64'h0);

    // Case 1/2/3: check value over "123456789" on all three 8-bit-beat configs
    send_msg(1'b1, 0);
    chk("c1_valid", 64'(cv8), 64'h1);
    chk("c1_crc8",  64'(crc8), 64'hF4);
    chk("c1_ready", 64'(rdy8), 64'h0);
    chk("c1_ok",    64'(ok8), 64'h0);
    chk("c2_crc16", 64'(crc16), 64'h29B1);
    chk("c3_crc32", 64'(crc32), 64'hCBF43926);
    @(posedge clk); #1;
    chk("c1_held", 64'(crc8), 64'hF4);
    handoff();
    chk("c1_valid_drop", 64'(cv8), 64'h0);
    chk("c1_crc_init",   64'(crc8), 64'h00);
    chk("c1_ready_back", 64'(rdy8), 64'h1);
    chk("c3_crc32_init", 64'(crc32), 64'h0);

    // Case 2b: 16-bit beats over "12345678"
    for (int i = 0; i < 4; i++) begin
      dw = 16'(16'h3132 + 16'h0202 * i); vw = 1'b1; lw = (i == 3);
      @(posedge clk); #1;
      vw = 1'b0; lw = 1'b0;
    end
    chk("c2w_valid", 64'(cvw), 64'h1);
    chk("c2w_crc",   64'(crcw), 64'(ccitt8(64'h3132333435363738)));
    crw = 1'b1; @(posedge clk); #1; crw = 1'b0;
    chk("c2w_init", 64'(crcw), 64'hFFFF);

    // Case 4: residue check with appended CRC
    send_msg(1'b0, 0);
    send(8'hF4, 1'b1);
    chk("c4_ok_good",  64'(ok8), 64'h1);
    chk("c4_crc_good", 64'(crc8), 64'h00);
    handoff();
    send_msg(1'b0, 0);
    send(8'hF5, 1'b1);
    chk("c4_ok_bad",  64'(ok8), 64'h0);
    chk("c4_crc_bad", 64'(crc8), 64'h07);
    handoff();

    // Case 5: gaps, stalled handoff, back-to-back frame
    send_msg(1'b1, 3);
    chk("c5_gap_crc", 64'(crc8), 64'hF4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("c5_hold_ready", 64'(rdy8), 64'h0);
      chk("c5_hold_crc",   64'(crc8), 64'hF4);
      chk("c5_hold_valid", 64'(cv8), 64'h1);
    end
    handoff();
    chk("c5_next_ready", 64'(rdy8), 64'h1);
    send_msg(1'b1, 0);
    chk("c5_next_crc", 64'(crc8), 64'hF4);
    handoff();

    // Case 6: clear mid-frame, clear in HOLD, beat with clear
    send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0); send(8'h34, 1'b0);
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    chk("c6_clear_crc", 64'(crc8), 64'h00);
    send_msg(1'b1, 0);
    chk("c6_after_clear", 64'(crc8), 64'hF4);
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    chk("c6_hold_clear_valid", 64'(cv8), 64'h0);
    chk("c6_hold_clear_crc",   64'(crc8), 64'h00);
    data = 8'h31; valid = 1'b1; clear = 1'b1;
    #1;
    chk("c6_clear_ready", 64'(rdy8), 64'h0);
    @(posedge clk); #1;
    valid = 1'b0; clear = 1'b0;
    chk("c6_clear_beat_crc",   64'(crc8), 64'h00);
    chk("c6_clear_beat_valid", 64'(cv8), 64'h0);

    // Case 6d: asynchronous reset between edges while holding a result
    send_msg(1'b1, 0);
    chk("c6_pre_rst_crc", 64'(crc8), 64'hF4);
    #3 rst_n = 1'b0;
    #1;
    chk("c6_rst_crc",   64'(crc8), 64'h00);
    chk("c6_rst_valid", 64'(cv8), 64'h0);
    chk("c6_rst_ready", 64'(rdy8), 64'h1);
    chk("c6_rst_ok",    64'(ok8), 64'h1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("c6_post_rst_valid", 64'(cv8), 64'h0);
    send_msg(1'b1, 0);
    chk("c6_post_rst_crc", 64'(crc8), 64'hF4);
    handoff();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
